// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative binary to packed-BCD converter (shift-and-add-3 / double dabble).
// One shift step per input bit. The input and output sides each have a
// valid/ready handshake. All handshake outputs are decoded from registered
// state, so there is no combinational path from in_valid or out_ready.
//
// Parameters:
//   BIN_W   width of the binary operand (>= 2)
//   DIGITS  number of BCD output digits; out_bcd is 4*DIGITS bits wide
//
// Ports:
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   in_valid   in_bin is valid
//   in_ready   converter can accept an operand (only in IDLE)
//   in_bin     binary operand (unsigned, or two's complement with SIGNED_EN)
//   out_valid  out_bcd/out_neg/out_ovf are valid (DONE)
//   out_ready  consumer accepts the result
//   out_bcd    packed BCD result, digit 0 in [3:0]
//   out_neg    result is negative (always 0 unless SIGNED_EN)
//   out_ovf    magnitude exceeded 10^DIGITS-1; out_bcd holds the low digits
//
// Build option:
//   SIGNED_EN  when defined, in_bin is two's complement. The sign is latched
//              into out_neg and the magnitude is converted.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q,   bin_d;
  logic [BCD_W-1:0] bcd_q,   bcd_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;
  logic [BIN_W-1:0] mag;
  logic [BCD_W-1:0] adj;

  // Add 3 to every digit that is 5 or more. Applying this before the shift
  // makes that digit carry into the next one after the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef SIGNED_EN
  logic neg_q, neg_d;

  // Two's-complement negation. The most negative value maps onto itself, and
  // that bit pattern read as unsigned is exactly 2^(BIN_W-1).
  assign mag = in_bin[BIN_W-1] ? (~in_bin + {{(BIN_W-1){1'b0}}, 1'b1}) : in_bin;
`else
  assign mag = in_bin;
`endif

  assign adj = add3(bcd_q);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = mag;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
`ifdef SIGNED_EN
          neg_d   = in_bin[BIN_W-1];
`endif
          state_d = CONV;
        end
      end
      CONV: begin
        // Shift {bcd, bin} left by one. A 1 that leaves the top digit means
        // the value does not fit in DIGITS digits, so the overflow flag stays
        // set until the next accept.
        bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | adj[BCD_W-1];
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign out_ovf   = ovf_q;
`ifdef SIGNED_EN
  assign out_neg   = neg_q;
`else
  assign out_neg   = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Scoreboard bench for bin_to_bcd_seq. One instance uses DIGITS=3 and a second
// uses DIGITS=2. Both share the same stimulus and run in lockstep. Expected
// results are computed from decimal arithmetic on the operand value.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 8;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    logic        neg;
    int          acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             nrst;
  logic             in_valid;
  logic [BIN_W-1:0] in_bin;
  logic             out_ready;
  logic             ir3, ov3, ng3, of3;
  logic             ir2, ov2, ng2, of2;
  logic [11:0]      bcd3;
  logic [7:0]       bcd2;

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  exp_t q3[$];
  exp_t q2[$];
  bit   pv[2], pr[2], irc[2], po[2];
  logic [11:0] pb[2];

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) u_d3 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(ir3), .in_bin(in_bin),
    .out_valid(ov3), .out_ready(out_ready), .out_bcd(bcd3), .out_neg(ng3), .out_ovf(of3));

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(2)) u_d2 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(ir2), .in_bin(in_bin),
    .out_valid(ov2), .out_ready(out_ready), .out_bcd(bcd2), .out_neg(ng2), .out_ovf(of2));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: decimal digits of the magnitude, modulo 10^d.
  function automatic exp_t model(input logic [BIN_W-1:0] v, input int d);
    exp_t e;
    int   mag, lim, r;
`ifdef SIGNED_EN
    e.neg = v[BIN_W-1];
    mag   = v[BIN_W-1] ? (1 << BIN_W) - int'(v) : int'(v);
`else
    e.neg = 1'b0;
    mag   = int'(v);
`endif
    lim   = 10 ** d;
    e.ovf = (mag >= lim);
    r     = mag % lim;
    e.bcd = '0;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.acc = 0;
    return e;
  endfunction

  // Called just after a rising edge. Holds in_valid/in_bin until accepted.
  // in_valid is left high so that operands can be issued back-to-back.
  task automatic send(input logic [BIN_W-1:0] v, input bit push);
    int   n;
    exp_t e3, e2;
    in_valid = 1'b1;
    in_bin   = v;
    n = 0;
    @(negedge clk);
    while (!ir3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ir3) fail("accept_timeout");
    else if (push) begin
      e3 = model(v, 3); e3.acc = cyc + 1;
      e2 = model(v, 2); e2.acc = cyc + 1;
      q3.push_back(e3);
      q2.push_back(e2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q3.size() != 0 || q2.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q3.size() != 0 || q2.size() != 0) begin
      fail("drain_timeout");
      q3.delete();
      q2.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_in_ready_d3", ir3, 1);  chk("rst_out_valid_d3", ov3, 0);
    chk("rst_bcd_d3", bcd3, 0);      chk("rst_ovf_d3", of3, 0);
    chk("rst_neg_d3", ng3, 0);
    chk("rst_in_ready_d2", ir2, 1);  chk("rst_out_valid_d2", ov2, 0);
    chk("rst_bcd_d2", bcd2, 0);      chk("rst_ovf_d2", of2, 0);
  endtask

  task automatic mon(input int id, input logic v, input logic [11:0] bcd,
                     input logic ovf, input logic neg, input logic ir);
    exp_t  e;
    string n;
    n = (id == 0) ? "d3" : "d2";
    if (irc[id]) begin
      chk({n, "_in_ready_after_hs"}, ir, 1);
      chk({n, "_out_valid_after_hs"}, v, 0);
      irc[id] = 0;
    end
    if (v && !pv[id]) begin
      if ((id == 0 ? q3.size() : q2.size()) == 0) fail({n, "_unexpected_output"});
      else begin
        e = (id == 0) ? q3[0] : q2[0];
        chk({n, "_latency"}, cyc - e.acc, BIN_W);
      end
    end
    if (v && pv[id] && !pr[id]) begin
      chk({n, "_hold_bcd"}, bcd, pb[id]);
      chk({n, "_hold_ovf"}, ovf, po[id]);
    end
    if (v && out_ready) begin
      if ((id == 0 ? q3.size() : q2.size()) == 0) fail({n, "_output_without_expect"});
      else begin
        e = (id == 0) ? q3.pop_front() : q2.pop_front();
        chk({n, "_bcd"}, bcd, e.bcd);
        chk({n, "_ovf"}, ovf, e.ovf);
        chk({n, "_neg"}, neg, e.neg);
      end
      irc[id] = 1;
    end
    pv[id] = v;
    pr[id] = out_ready;
    pb[id] = bcd;
    po[id] = ovf;
  endtask

  initial forever begin
    @(negedge clk);
    if (nrst === 1'b1) begin
      mon(0, ov3, bcd3, of3, ng3, ir3);
      mon(1, ov2, {4'h0, bcd2}, of2, ng2, ir2);
    end else begin
      pv[0] = 0; pv[1] = 0; irc[0] = 0; irc[1] = 0;
    end
  end

  initial begin
    bit done;
    nrst = 1'b0; in_valid = 1'b0; in_bin = '0; out_ready = 1'b1;
    #3;
    check_reset();
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk);
    #1;

    // Full-scale value.
    send(8'd255, 1); in_valid = 1'b0; drain();

    // Back-to-back with in_valid held.
    send(8'd0, 1); send(8'd99, 1); send(8'd100, 1); in_valid = 1'b0; drain();

    // Back-pressure: hold the result while a new operand waits.
    out_ready = 1'b0;
    send(8'd42, 1);
    fork
      send(8'd7, 1);
      begin
        repeat (BIN_W + 20) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    in_valid = 1'b0; drain();

    // Overflow in the two-digit instance, then signed-range corner values.
    send(8'd123, 1); send(8'd99, 1);
    send(8'h80, 1);  send(8'hFF, 1); send(8'h7F, 1);
    in_valid = 1'b0; drain();

    // Reset on the 4th conversion cycle discards the partial result.
    send(8'd200, 0); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 nrst = 1'b0;
    #1 check_reset();
    @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk);
    #1;
    send(8'd17, 1); in_valid = 1'b0; drain();

    // Random operands with random back-pressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(BIN_W'($urandom_range(0, 255)), 1);
          if ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Iterative binary-to-packed-BCD converter using the shift-and-add-3 (double dabble) method. It produces the decimal operands consumed by the team's BCD adder/subtractor datapath and is the converse of the BCD arithmetic path. It uses one shift step per input bit, with valid/ready handshakes on both sides.

Parameters:
BIN_W, 8, width of binary input (>=2)
DIGITS, 3, number of BCD output digits; output width 4*DIGITS

Ports:
clk  input  1  rising-edge clock
nrst  input  1  asynchronous active-low reset
in_valid  input  1  in_bin valid
in_ready  output  1  converter can accept a new operand
in_bin  input  BIN_W  binary operand (unsigned; two's complement when SIGNED_EN)
out_valid  output  1  out_bcd/out_neg/out_ovf valid
out_ready  input  1  consumer accepts result
out_bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]
out_neg  output  1  result negative (SIGNED_EN only; else constant 0)
out_ovf  output  1  value exceeded 10^DIGITS-1; out_bcd holds low DIGITS digits

Behaviour:
- Reset (nrst low, asynchronous): state IDLE, in_ready=1, out_valid=0, out_bcd=0, out_neg=0, out_ovf=0, bit counter=0.
- Clock and reset are fixed: one clock (clk); reset nrst is asynchronous and active-low; deassertion is sampled on clk.
- States: IDLE -> CONV -> DONE -> IDLE.
- IDLE: in_ready=1. On an edge with in_valid=1, the accept edge:
  - load the shift register with the magnitude, clear the BCD accumulator and ovf, set counter=BIN_W, go to CONV.
- CONV: in_ready=0, out_valid=0. Each edge:
  - for every digit >=5, add 3 to that digit (combinational, all digits in parallel);
  - shift {bcd, bin} left 1;
  - if a 1 leaves the top digit, set ovf (sticky);
  - decrement counter; the edge that takes counter 1->0 moves to DONE.
- Latency: out_valid rises exactly BIN_W edges after the accept edge. Throughput: one result per BIN_W+2 cycles at best.
- DONE: out_valid=1, in_ready=0. Outputs hold stable while out_ready=0, for unbounded back-pressure. On an edge with out_ready=1, go to IDLE and drop out_valid. out_bcd/out_neg/out_ovf keep their last values (not cleared).
- in_valid while not in IDLE is ignored; no operand is queued. Producer must hold in_valid and in_bin until in_ready.
- out_ready in IDLE/CONV has no effect.
- No combinational path from in_valid to in_ready or from out_ready to out_valid; all handshake outputs are registered.
- Reset mid-conversion aborts immediately; the partial result is discarded.
- Arithmetic: digits never exceed 9 after any shift when DIGITS >= ceil(BIN_W*log10(2)).
- With smaller DIGITS, out_ovf=1 when the value does not fit, and out_bcd holds the low digits (value mod 10^DIGITS).

Optional Feature:
SIGNED_EN
- Defined: in_bin is two's complement.
- On accept, out_neg latches in_bin[BIN_W-1], and the magnitude (negated if negative) is loaded.
- Most negative value -2^(BIN_W-1) converts as magnitude 2^(BIN_W-1) with out_neg=1.
- Zero gives out_neg=0.
- Not defined: in_bin is unsigned; out_neg is tied to 0; no negation logic is present.

Test Plan:
- in_bin=8'd255, out_ready=1 -> out_valid exactly 8 edges after accept; out_bcd=12'h255, out_ovf=0; in_ready returns 1 the cycle after the handshake.
- in_bin=0, then 8'd99, then 8'd100 back-to-back (in_valid held) -> 12'h000, 12'h099, 12'h100; each accepted only when in_ready=1.
- in_bin=8'd42, out_ready low for 20 cycles -> out_valid and out_bcd=12'h042 stable throughout; a new in_valid with value 8'd7 is not accepted until after the output handshake.
- DIGITS=2, in_bin=8'd123 -> out_bcd=8'h23, out_ovf=1; in_bin=8'd99 -> 8'h99, out_ovf=0.
- nrst pulsed low on the 4th CONV cycle of in_bin=8'd200 -> all outputs at reset values immediately; next operand 8'd17 -> 12'h017 with correct latency.
- SIGNED_EN: in_bin=8'h80 -> out_neg=1, out_bcd=12'h128; 8'hFF -> out_neg=1, 12'h001; 8'h7F -> out_neg=0, 12'h127.
